// File: rtl/eth_axis_frame_gen.sv
// Ethernet test-frame burst generator driving an 8-bit AXI-Stream MAC TX port.
// Define ETH_FRAME_GEN_SEQNUM_EN to put the frame sequence number in payload bytes 0-1.
module eth_axis_frame_gen #(
   parameter logic [47:0] DST_MAC   = 48'hFFFFFFFFFFFF,
   parameter logic [47:0] SRC_MAC   = 48'h020000000001,
   parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
   input  logic        clock125,
   input  logic        resetn,
   input  logic        start,
   input  logic [15:0] frame_count,
   input  logic [10:0] payload_len,
   input  logic [7:0]  gap_cycles,
   output logic [7:0]  tx_axis_tdata,
   output logic        tx_axis_tkeep,
   output logic        tx_axis_tvalid,
   input  logic        tx_axis_tready,
   output logic        tx_axis_tlast,
   output logic        tx_axis_tuser,
   output logic        busy,
   output logic        done,
   output logic [15:0] frames_sent
);

   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, GAP, FIN} state_t;

   localparam logic [111:0] HDR_BYTES = {DST_MAC, SRC_MAC, ETHERTYPE};

   state_t       state, state_nxt;
   logic [15:0]  frame_count_q;
   logic [10:0]  len_q;
   logic [7:0]   gap_q;
   logic [10:0]  byte_cnt;
   logic [7:0]   gap_cnt;
   logic [10:0]  len_clamped;
   logic [111:0] hdr_shift;
   logic [7:0]   hdr_byte;
   logic [7:0]   pay_byte;
   logic         beat;
   logic         accept;
   logic         last_hdr;
   logic         last_pay;
   logic         last_frame;
   logic         gap_end;

   assign accept      = (state == IDLE) && start;
   assign beat        = tx_axis_tvalid && tx_axis_tready;
   assign last_hdr    = (byte_cnt == 11'd13);
   assign last_pay    = (byte_cnt == (len_q - 11'd1));
   assign last_frame  = ((frames_sent + 16'd1) == frame_count_q);
   // GAP always lasts at least one cycle, so gap_cycles=0 still drops tvalid once
   assign gap_end     = (gap_q == 8'd0) || (gap_cnt == (gap_q - 8'd1));

   assign len_clamped = (payload_len < 11'd46)   ? 11'd46   :
                        (payload_len > 11'd1500) ? 11'd1500 : payload_len;

   assign hdr_shift   = HDR_BYTES << {byte_cnt[3:0], 3'b000};
   assign hdr_byte    = hdr_shift[111:104];

`ifdef ETH_FRAME_GEN_SEQNUM_EN
   always_comb begin
      pay_byte = byte_cnt[7:0];
      if (byte_cnt == 11'd0)
         pay_byte = frames_sent[15:8];
      else if (byte_cnt == 11'd1)
         pay_byte = frames_sent[7:0];
   end
`else
   assign pay_byte = byte_cnt[7:0];
`endif

   always_ff @(posedge clock125 or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (frame_count == 16'd0) ? FIN : HDR;
         HDR:     if (beat && last_hdr) state_nxt = PAYLOAD;
         PAYLOAD: if (beat && last_pay) state_nxt = last_frame ? FIN : GAP;
         GAP:     if (gap_end) state_nxt = HDR;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_axis_tvalid = 1'b0;
      tx_axis_tdata  = '0;
      tx_axis_tlast  = 1'b0;
      case (state)
         HDR: begin
            tx_axis_tvalid = 1'b1;
            tx_axis_tdata  = hdr_byte;
         end
         PAYLOAD: begin
            tx_axis_tvalid = 1'b1;
            tx_axis_tdata  = pay_byte;
            tx_axis_tlast  = last_pay;
         end
         default: ;
      endcase
   end

   assign tx_axis_tkeep = 1'b1;
   assign tx_axis_tuser = 1'b0;

   always_ff @(posedge clock125 or negedge resetn) begin
      if (!resetn) begin
         frame_count_q <= '0;
         len_q         <= 11'd46;
         gap_q         <= '0;
      end else if (accept) begin
         frame_count_q <= frame_count;
         len_q         <= len_clamped;
         gap_q         <= gap_cycles;
      end
   end

   always_ff @(posedge clock125 or negedge resetn) begin
      if (!resetn) begin
         byte_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         if ((state == HDR || state == PAYLOAD) && beat)
            byte_cnt <= ((state == HDR && last_hdr) || (state == PAYLOAD && last_pay)) ?
                        11'd0 : byte_cnt + 11'd1;
         else if (state != HDR && state != PAYLOAD)
            byte_cnt <= '0;
         gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      end
   end

   always_ff @(posedge clock125 or negedge resetn) begin
      if (!resetn) begin
         frames_sent <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         done <= (state == FIN);
         if (accept) begin
            frames_sent <= '0;
            busy        <= 1'b1;
         end else if (state == FIN) begin
            busy        <= 1'b0;
         end
         if (state == PAYLOAD && beat && last_pay)
            frames_sent <= frames_sent + 16'd1;
      end
   end

endmodule

// File: tb/tb_eth_axis_frame_gen.sv
// Directed self-checking bench for eth_axis_frame_gen; honours ETH_FRAME_GEN_SEQNUM_EN when defined.
module tb_eth_axis_frame_gen;

   logic        clock125;
   logic        resetn;
   logic        start;
   logic [15:0] frame_count;
   logic [10:0] payload_len;
   logic [7:0]  gap_cycles;
   logic [7:0]  tx_axis_tdata;
   logic        tx_axis_tkeep;
   logic        tx_axis_tvalid;
   logic        tx_axis_tready;
   logic        tx_axis_tlast;
   logic        tx_axis_tuser;
   logic        busy;
   logic        done;
   logic [15:0] frames_sent;

   int checks   = 0;
   int failures = 0;

   logic [7:0] cap_data[$];
   logic       cap_last[$];
   int         gaps[$];
   int         done_cyc;
   int         stall_err;
   logic       busy_c1;

   eth_axis_frame_gen #(
      .DST_MAC   (48'hFFFFFFFFFFFF),
      .SRC_MAC   (48'h020000000001),
      .ETHERTYPE (16'h88B5)
   ) dut (
      .clock125       (clock125),
      .resetn         (resetn),
      .start          (start),
      .frame_count    (frame_count),
      .payload_len    (payload_len),
      .gap_cycles     (gap_cycles),
      .tx_axis_tdata  (tx_axis_tdata),
      .tx_axis_tkeep  (tx_axis_tkeep),
      .tx_axis_tvalid (tx_axis_tvalid),
      .tx_axis_tready (tx_axis_tready),
      .tx_axis_tlast  (tx_axis_tlast),
      .tx_axis_tuser  (tx_axis_tuser),
      .busy           (busy),
      .done           (done),
      .frames_sent    (frames_sent)
   );

   initial clock125 = 1'b0;
   always #4 clock125 = ~clock125;

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int clamp_len(input int len);
      if (len < 46) return 46;
      if (len > 1500) return 1500;
      return len;
   endfunction

   function automatic logic [7:0] exp_byte(input int unsigned frame, input int unsigned idx);
      logic [111:0] hdr;
      logic [15:0]  fr;
      int unsigned  p;
      hdr = {48'hFFFFFFFFFFFF, 48'h020000000001, 16'h88B5};
      fr  = frame[15:0];
      if (idx < 14) return hdr[111 - 8*idx -: 8];
      p = idx - 14;
`ifdef ETH_FRAME_GEN_SEQNUM_EN
      if (p == 0) return fr[15:8];
      if (p == 1) return fr[7:0];
`endif
      return p[7:0];
   endfunction

   // Number of captured beats that disagree with the reference frame model.
   function automatic int model_mismatches(input int flen);
      int bad;
      bad = 0;
      for (int b = 0; b < cap_data.size(); b++) begin
         if (cap_data[b] !== exp_byte(b / flen, b % flen)) bad++;
         if (cap_last[b] !== ((b % flen) == flen - 1)) bad++;
      end
      return bad;
   endfunction

   task automatic run_burst(input int fc, input int len, input int gap, input bit toggle,
                            input int busy_start_cyc, input int max_cyc);
      logic prev_stall, seen_last;
      logic [7:0] prev_data;
      logic prev_last;
      int idle_run;
      cap_data.delete();
      cap_last.delete();
      gaps.delete();
      done_cyc   = -1;
      stall_err  = 0;
      busy_c1    = 1'b0;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_last  = 1'b0;
      seen_last  = 1'b0;
      idle_run   = 0;
      @(negedge clock125);
      frame_count    = fc[15:0];
      payload_len    = len[10:0];
      gap_cycles     = gap[7:0];
      tx_axis_tready = 1'b1;
      start          = 1'b1;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         @(negedge clock125);
         start = (cyc == busy_start_cyc);
         if (cyc == busy_start_cyc) begin
            frame_count = 16'd5;
            payload_len = 11'd100;
            gap_cycles  = 8'd9;
         end
         tx_axis_tready = toggle ? cyc[0] : 1'b1;
         #1;
         if (cyc == 1) busy_c1 = busy;
         if (prev_stall && (tx_axis_tdata !== prev_data || tx_axis_tlast !== prev_last))
            stall_err++;
         prev_stall = tx_axis_tvalid && !tx_axis_tready;
         prev_data  = tx_axis_tdata;
         prev_last  = tx_axis_tlast;
         if (tx_axis_tvalid) begin
            if (seen_last) begin
               gaps.push_back(idle_run);
               seen_last = 1'b0;
            end
            if (tx_axis_tready) begin
               cap_data.push_back(tx_axis_tdata);
               cap_last.push_back(tx_axis_tlast);
               if (tx_axis_tlast) begin
                  seen_last = 1'b1;
                  idle_run  = 0;
               end
            end
         end else if (seen_last) begin
            idle_run++;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      start          = 1'b0;
      tx_axis_tready = 1'b1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clock125);
      #1;
      checks++; if (tx_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", tx_axis_tvalid); end
      checks++; if (tx_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", tx_axis_tlast); end
      checks++; if (tx_axis_tdata !== 8'h00) begin failures++; $display("FAIL reset_tdata got=%h exp=00", tx_axis_tdata); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (frames_sent !== 16'd0) begin failures++; $display("FAIL reset_frames_sent got=%0d exp=0", frames_sent); end
      checks++; if (tx_axis_tkeep !== 1'b1 || tx_axis_tuser !== 1'b0) begin failures++; $display("FAIL reset_keep_user got=%b%b exp=10", tx_axis_tkeep, tx_axis_tuser); end
      @(negedge clock125);
      resetn = 1'b1;
      repeat (2) @(negedge clock125);
   endtask

   task automatic test_single_frame;
      int n;
      run_burst(1, 46, 0, 1'b0, 0, 200);
      n = cap_data.size();
      checks++; if (n !== 60) begin failures++; $display("FAIL single_beats got=%0d exp=60", n); end
      if (n == 60) begin
         checks++; if (cap_data[0] !== 8'hFF || cap_data[5] !== 8'hFF) begin failures++; $display("FAIL single_dst got=%h,%h exp=FF,FF", cap_data[0], cap_data[5]); end
         checks++; if (cap_data[12] !== 8'h88 || cap_data[13] !== 8'hB5) begin failures++; $display("FAIL single_ethertype got=%h%h exp=88B5", cap_data[12], cap_data[13]); end
         checks++; if (cap_data[14] !== 8'h00) begin failures++; $display("FAIL single_pay0 got=%h exp=00", cap_data[14]); end
         checks++; if (cap_data[59] !== 8'h2D || cap_last[59] !== 1'b1) begin failures++; $display("FAIL single_last got=%h/%b exp=2D/1", cap_data[59], cap_last[59]); end
      end
      checks++; if (model_mismatches(60) !== 0) begin failures++; $display("FAIL single_model got=%0d bad beats exp=0", model_mismatches(60)); end
      checks++; if (done_cyc < 0) begin failures++; $display("FAIL single_done got=timeout exp=pulse"); end
      checks++; if (frames_sent !== 16'd1 || busy !== 1'b0) begin failures++; $display("FAIL single_status got=%0d/%b exp=1/0", frames_sent, busy); end
      @(negedge clock125); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b exp=0", done); end
   endtask

   task automatic test_clamp;
      run_burst(1, 10, 0, 1'b0, 0, 200);
      checks++; if (cap_data.size() !== 60) begin failures++; $display("FAIL clamp_low_beats got=%0d exp=60", cap_data.size()); end
      checks++; if (model_mismatches(60) !== 0) begin failures++; $display("FAIL clamp_low_model got=%0d exp=0", model_mismatches(60)); end
      run_burst(1, 2000, 0, 1'b0, 0, 2000);
      checks++; if (cap_data.size() !== 1514) begin failures++; $display("FAIL clamp_high_beats got=%0d exp=1514", cap_data.size()); end
      checks++; if (model_mismatches(1514) !== 0) begin failures++; $display("FAIL clamp_high_model got=%0d exp=0", model_mismatches(1514)); end
      if (cap_data.size() == 1514) begin
         checks++; if (cap_data[1513] !== 8'hDB) begin failures++; $display("FAIL clamp_high_lastbyte got=%h exp=DB", cap_data[1513]); end
      end
   endtask

   task automatic test_backpressure;
      run_burst(1, 64, 0, 1'b1, 0, 400);
      checks++; if (cap_data.size() !== 78) begin failures++; $display("FAIL bp_beats got=%0d exp=78", cap_data.size()); end
      checks++; if (model_mismatches(78) !== 0) begin failures++; $display("FAIL bp_model got=%0d exp=0", model_mismatches(78)); end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL bp_stall_stable got=%0d changes exp=0", stall_err); end
      checks++; if (done_cyc < 0) begin failures++; $display("FAIL bp_done got=timeout exp=pulse"); end
   endtask

   task automatic test_multi_frame;
      run_burst(3, 46, 5, 1'b0, 0, 400);
      checks++; if (cap_data.size() !== 180) begin failures++; $display("FAIL multi_beats got=%0d exp=180", cap_data.size()); end
      checks++; if (model_mismatches(60) !== 0) begin failures++; $display("FAIL multi_model got=%0d exp=0", model_mismatches(60)); end
      checks++; if (gaps.size() !== 2) begin failures++; $display("FAIL multi_gap_count got=%0d exp=2", gaps.size()); end
      if (gaps.size() == 2) begin
         checks++; if (gaps[0] !== 5 || gaps[1] !== 5) begin failures++; $display("FAIL multi_gap_len got=%0d,%0d exp=5,5", gaps[0], gaps[1]); end
      end
      checks++; if (frames_sent !== 16'd3) begin failures++; $display("FAIL multi_frames_sent got=%0d exp=3", frames_sent); end
   endtask

   task automatic test_gap_zero;
      run_burst(2, 46, 0, 1'b0, 0, 300);
      checks++; if (cap_data.size() !== 120) begin failures++; $display("FAIL gap0_beats got=%0d exp=120", cap_data.size()); end
      checks++; if (gaps.size() !== 1 || (gaps.size() == 1 && gaps[0] !== 1)) begin failures++; $display("FAIL gap0_drop got=%0d gaps exp=1 gap of 1", gaps.size()); end
   endtask

   task automatic test_zero_frames;
      run_burst(0, 46, 0, 1'b0, 0, 20);
      checks++; if (cap_data.size() !== 0) begin failures++; $display("FAIL zero_beats got=%0d exp=0", cap_data.size()); end
      checks++; if (done_cyc !== 2) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=2", done_cyc); end
      checks++; if (busy_c1 !== 1'b1) begin failures++; $display("FAIL zero_busy got=%b exp=1", busy_c1); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_start_while_busy;
      run_burst(1, 46, 0, 1'b0, 3, 200);
      checks++; if (cap_data.size() !== 60) begin failures++; $display("FAIL busy_start_beats got=%0d exp=60", cap_data.size()); end
      checks++; if (model_mismatches(60) !== 0) begin failures++; $display("FAIL busy_start_model got=%0d exp=0", model_mismatches(60)); end
      checks++; if (frames_sent !== 16'd1) begin failures++; $display("FAIL busy_start_frames got=%0d exp=1", frames_sent); end
      repeat (4) @(negedge clock125);
      #1;
      checks++; if (busy !== 1'b0 || tx_axis_tvalid !== 1'b0) begin failures++; $display("FAIL busy_start_idle got=%b/%b exp=0/0", busy, tx_axis_tvalid); end
   endtask

   task automatic test_seqnum;
      run_burst(2, 46, 2, 1'b0, 0, 300);
      checks++; if (cap_data.size() !== 120) begin failures++; $display("FAIL seq_beats got=%0d exp=120", cap_data.size()); end
      if (cap_data.size() == 120) begin
`ifdef ETH_FRAME_GEN_SEQNUM_EN
         checks++; if (cap_data[14] !== 8'h00 || cap_data[15] !== 8'h00 || cap_data[74] !== 8'h00 || cap_data[75] !== 8'h01) begin
            failures++; $display("FAIL seq_bytes got=%h%h,%h%h exp=0000,0001", cap_data[14], cap_data[15], cap_data[74], cap_data[75]); end
`else
         checks++; if (cap_data[14] !== 8'h00 || cap_data[15] !== 8'h01 || cap_data[74] !== 8'h00 || cap_data[75] !== 8'h01) begin
            failures++; $display("FAIL seq_bytes got=%h%h,%h%h exp=0001,0001", cap_data[14], cap_data[15], cap_data[74], cap_data[75]); end
`endif
      end
      checks++; if (model_mismatches(60) !== 0) begin failures++; $display("FAIL seq_model got=%0d exp=0", model_mismatches(60)); end
   endtask

   task automatic test_reset_mid_frame;
      int beats, late_valid;
      beats = 0;
      late_valid = 0;
      @(negedge clock125);
      frame_count    = 16'd2;
      payload_len    = 11'd46;
      gap_cycles     = 8'd0;
      tx_axis_tready = 1'b1;
      start          = 1'b1;
      for (int cyc = 0; cyc < 100 && beats < 20; cyc++) begin
         @(negedge clock125);
         start = 1'b0;
         #1;
         if (tx_axis_tvalid) beats++;
      end
      checks++; if (beats !== 20) begin failures++; $display("FAIL rst_mid_progress got=%0d exp=20", beats); end
      #1 resetn = 1'b0;
      #1;
      checks++; if (tx_axis_tvalid !== 1'b0 || tx_axis_tlast !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs got=%b/%b exp=0/0", tx_axis_tvalid, tx_axis_tlast); end
      checks++; if (busy !== 1'b0 || frames_sent !== 16'd0) begin failures++; $display("FAIL rst_mid_status got=%b/%0d exp=0/0", busy, frames_sent); end
      @(negedge clock125);
      resetn = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         @(negedge clock125);
         #1;
         if (tx_axis_tvalid || tx_axis_tlast) late_valid++;
      end
      checks++; if (late_valid !== 0) begin failures++; $display("FAIL rst_mid_resume got=%0d active cycles exp=0", late_valid); end
   endtask

   initial begin
      resetn         = 1'b0;
      start          = 1'b0;
      frame_count    = '0;
      payload_len    = '0;
      gap_cycles     = '0;
      tx_axis_tready = 1'b1;
      test_reset();
      test_single_frame();
      test_clamp();
      test_backpressure();
      test_multi_frame();
      test_gap_zero();
      test_zero_frames();
      test_start_while_busy();
      test_seqnum();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/eth_axis_frame_gen.md
ETH_AXIS_FRAME_GEN -- requirements
Module: eth_axis_frame_gen

Interface
REQ-001 SHALL have parameter DST_MAC, default 48'hFFFFFFFFFFFF, destination MAC inserted in header bytes 0-5.
REQ-002 SHALL have parameter SRC_MAC, default 48'h020000000001, source MAC inserted in header bytes 6-11.
REQ-003 SHALL have parameter ETHERTYPE, default 16'h88B5, inserted in header bytes 12-13.
REQ-004 SHALL have port clock125  input  1  sole clock, 125 MHz, drives all logic and TX_AXIS; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to begin a burst.
REQ-007 SHALL have port frame_count  input  16  number of frames in burst, sampled when start accepted.
REQ-008 SHALL have port payload_len  input  11  payload bytes per frame, sampled when start accepted.
REQ-009 SHALL have port gap_cycles  input  8  idle cycles between frames, sampled when start accepted.
REQ-010 SHALL have ports tx_axis_tdata  output  8, tx_axis_tkeep  output  1, tx_axis_tvalid  output  1, tx_axis_tready  input  1, tx_axis_tlast  output  1, tx_axis_tuser  output  1  AXI-Stream master toward MAC TX_AXIS.
REQ-011 SHALL have ports busy  output  1  burst in progress; done  output  1  one-cycle burst-complete pulse; frames_sent  output  16  frames completed in current/last burst.

Function
REQ-012 SHALL implement states IDLE, HDR, PAYLOAD, GAP, FIN.
REQ-013 IDLE: start=1 SHALL latch inputs, clear frames_sent, assert busy next cycle, go HDR (or FIN if frame_count=0).
REQ-014 start while busy SHALL be ignored, no latched input changes.
REQ-015 HDR SHALL emit 14 header bytes, MSB-first per field; PAYLOAD SHALL follow.
REQ-016 Latched payload length SHALL be clamped: below 46 -> 46, above 1500 -> 1500.
REQ-017 Payload byte index i (0-based) SHALL carry i[7:0] unless overridden by REQ-031.
REQ-018 tx_axis_tlast SHALL be 1 only on the final payload byte; frame length in beats = 14 + clamped length.
REQ-019 A beat SHALL advance only on tvalid&&tready; while tvalid=1 and tready=0, tdata/tlast SHALL hold stable.
REQ-020 tvalid SHALL be 1 continuously in HDR and PAYLOAD (no bubbles), 0 in IDLE/GAP/FIN.
REQ-021 tkeep SHALL be constant 1; tuser SHALL be constant 0.
REQ-022 On tlast handshake frames_sent SHALL increment; if frames_sent+1 = frame_count go FIN, else GAP.
REQ-023 GAP SHALL hold exactly gap_cycles cycles with tvalid=0; gap_cycles=0 SHALL go directly to HDR the cycle after the tlast handshake (one-cycle tvalid drop).
REQ-024 FIN SHALL pulse done=1 for one cycle, deassert busy same cycle, return IDLE.
REQ-025 frame_count=0 SHALL produce no beats; done SHALL pulse two cycles after start.
REQ-026 Byte counter SHALL be 11 bits; no wrap within a frame.

Reset
REQ-027 resetn=0 SHALL asynchronously force IDLE, tvalid=0, tlast=0, tdata=0, busy=0, done=0, frames_sent=0.
REQ-028 Reset mid-frame SHALL truncate the frame without tlast; no resume after release.
REQ-029 First start SHALL be honoured no earlier than the first clock125 edge after resetn deasserts.

Configuration
REQ-030 Macro ETH_FRAME_GEN_SEQNUM_EN SHALL select sequence-number insertion.
REQ-031 With macro defined: payload bytes 0-1 SHALL carry frames_sent value (big-endian) of the frame; bytes i>=2 carry i[7:0].
REQ-032 Without macro: all payload bytes per REQ-017; no sequence logic synthesized.

Verification
REQ-033 frame_count=1, payload_len=46, tready=1 -> 60 beats; beats 0-5 = FF, 12-13 = 88,B5, beat 14 = 00, beat 59 = 2D with tlast; done one cycle later, frames_sent=1.
REQ-034 payload_len=10 then 2000 -> 60 and 1514 beats respectively.
REQ-035 tready toggled 1/0 each cycle, payload_len=64 -> identical 78-byte sequence, tdata stable during stalls.
REQ-036 frame_count=3, gap_cycles=5 -> three frames, exactly 5 tvalid=0 cycles between tlast and next beat 0; frames_sent=3.
REQ-037 frame_count=0 -> no tvalid, done two cycles after start; start while busy -> ignored.
REQ-038 ETH_FRAME_GEN_SEQNUM_EN, frame_count=2 -> payload bytes 0-1 = 00,00 then 00,01; resetn pulse mid-payload -> tvalid=0 immediately, no tlast.
